playbus_responder: RTL and testbench
====================================

// Module: playbus_responder
// PURPOSE
//  Target side of the PlayBus level 1 interface: responds to the strobes from the bus controller
//  (ROMO, RAMO, RAMW, SWBEN, LEDLTCH).
//  Holds a small ROM, a read/write RAM, a synchronised switch port and an LED latch.
//  Returns registered read data to the datapath.
//  Flags illegal multi-driver strobe combinations.
// PARAMETERS
//  DATA_W    8      bus data width
//  ADDR_W    4      address width; RAM/ROM depth = 2**ADDR_W
//  ROM_BASE  8'h10  ROM word at address 0
//  ROM_STEP  3      ROM increment per address
// PORTS
//  clk       in   1       system clock, all state updates on rising edge
//  reset     in   1       synchronous, active-high reset
//  addr      in   ADDR_W  word address for ROM/RAM access
//  bus_in    in   DATA_W  write data from datapath
//  ROMO      in   1       ROM output enable
//  RAMO      in   1       RAM output enable
//  RAMW      in   1       RAM write strobe
//  SWBEN     in   1       switch buffer enable
//  LEDLTCH   in   1       LED latch strobe
//  switches  in   DATA_W  asynchronous board switches
//  bus_out   out  DATA_W  registered read data
//  bus_valid out  1       bus_out holds data from the previous cycle's read
//  leds      out  DATA_W  latched LED pattern
//  conflict  out  1       sticky: more than one read enable seen
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  - Reset (has priority over all other activity):
//    - bus_out=0, bus_valid=0, leds=0, conflict=0, both switch sync stages=0.
//    - RAM contents are NOT cleared.
//  - ROM: combinational constant rom[a] = (ROM_BASE + a*ROM_STEP) mod 2**DATA_W.
//    - Defaults: rom[0]=8'h10, rom[5]=8'h1F, rom[15]=8'h3D.
//  - Switches: two-flop synchroniser (sw_s1 <= switches; sw_s2 <= sw_s1).
//    - SWBEN returns sw_s2.
//    - A switch change is readable 2 edges later.
//  - Read select, evaluated each edge; nrd = ROMO+RAMO+SWBEN:
//    - nrd==1: bus_out <= selected source (rom[addr], ram[addr] or sw_s2); bus_valid <= 1.
//    - nrd==0: bus_out <= 0; bus_valid <= 0.
//    - nrd>=2: bus_out <= 0; bus_valid <= 0; conflict <= 1.
//    - Read latency: 1 cycle. Strobe sampled at edge N gives data on bus_out after edge N.
//  - conflict is sticky. Only reset clears it.
//    - A conflict does not block writes in the same cycle.
//  - RAMW: ram[addr] <= bus_in at the edge. Any addr value is legal; no wrap issues.
//  - RAMW and RAMO together, same addr: read-before-write.
//    - bus_out gets the OLD word.
//    - The new word is visible on the next read.
//  - LEDLTCH: leds <= bus_in. leds holds otherwise.
//    - RAMW and LEDLTCH may be asserted together; both capture bus_in.
//  - Writes and reads may coincide in one cycle. They are independent, apart from the
//    read-before-write rule.
//  - Reset asserted mid-operation:
//    - Any write strobed in that same cycle is discarded.
//    - Outputs take their reset values at that edge.
//  - No combinational path from inputs to outputs.
// TESTING
//  1. reset=1 for 2 cycles, all strobes low
//     -> bus_out=0, bus_valid=0, leds=0, conflict=0.
//  2. ROMO=1 with addr=0, then addr=5, then addr=15
//     -> bus_out 8'h10, 8'h1F, 8'h3D, each one cycle later; bus_valid=1.
//  3. RAMW addr=3 bus_in=8'hA5, then RAMO addr=3 -> bus_out=8'hA5.
//     Then RAMW+RAMO addr=3 bus_in=8'h5A -> bus_out=8'hA5.
//     Then RAMO -> bus_out=8'h5A.
//  4. switches=8'hC3, SWBEN=1 held
//     -> bus_out changes to 8'hC3 exactly 3 edges after the switch change.
//  5. LEDLTCH bus_in=8'h81 -> leds=8'h81, held while LEDLTCH=0.
//     Then reset pulse -> leds=0.
//  6. ROMO+RAMO together -> conflict=1, bus_valid=0, bus_out=0.
//     conflict stays 1 through later legal reads; a reset pulse clears it.

Source files
------------

// File: rtl/playbus_responder.sv
// PlayBus level 1 target: ROM, read/write RAM, synchronised switch port and LED latch,
// answering controller strobes with registered read data and a sticky conflict flag.
module playbus_responder #(
   parameter int unsigned          DATA_W   = 8,
   parameter int unsigned          ADDR_W   = 4,
   parameter logic [DATA_W-1:0]    ROM_BASE = 8'h10,
   parameter int unsigned          ROM_STEP = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] bus_in,
   input  logic              ROMO,
   input  logic              RAMO,
   input  logic              RAMW,
   input  logic              SWBEN,
   input  logic              LEDLTCH,
   input  logic [DATA_W-1:0] switches,
   output logic [DATA_W-1:0] bus_out,
   output logic              bus_valid,
   output logic [DATA_W-1:0] leds,
   output logic              conflict
);

   logic [DATA_W-1:0] ram [2**ADDR_W];
   logic [DATA_W-1:0] sw_s1;
   logic [DATA_W-1:0] sw_s2;
   logic [DATA_W-1:0] rom_word;
   logic [DATA_W-1:0] rd_data;
   logic [1:0]        nrd;

   always_comb begin
      rom_word = ROM_BASE + DATA_W'(int'(addr) * int'(ROM_STEP));
   end

   always_comb begin
      nrd = {1'b0, ROMO} + {1'b0, RAMO} + {1'b0, SWBEN};
   end

   // Only meaningful when exactly one read enable is active.
   always_comb begin
      rd_data = '0;
      if (ROMO)
         rd_data = rom_word;
      else if (RAMO)
         rd_data = ram[addr];
      else if (SWBEN)
         rd_data = sw_s2;
   end

   // RAM has no reset; a write coinciding with reset is dropped. Reading ram[addr]
   // above before this edge gives read-before-write on a shared address.
   always_ff @(posedge clk) begin
      if (!reset && RAMW)
         ram[addr] <= bus_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sw_s1     <= '0;
         sw_s2     <= '0;
         bus_out   <= '0;
         bus_valid <= 1'b0;
         leds      <= '0;
         conflict  <= 1'b0;
      end else begin
         sw_s1 <= switches;
         sw_s2 <= sw_s1;
         if (nrd == 2'd1) begin
            bus_out   <= rd_data;
            bus_valid <= 1'b1;
         end else begin
            bus_out   <= '0;
            bus_valid <= 1'b0;
         end
         if (nrd >= 2'd2)
            conflict <= 1'b1;
         if (LEDLTCH)
            leds <= bus_in;
      end
   end

endmodule

// File: tb/tb_playbus_responder.sv
// Scoreboard bench for playbus_responder: directed strobe vectors push hand-computed
// expectations; a monitor pops and compares one entry after each following rising edge.
module tb_playbus_responder;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] addr;
   logic [7:0] bus_in;
   logic       ROMO, RAMO, RAMW, SWBEN, LEDLTCH;
   logic [7:0] switches;
   logic [7:0] bus_out;
   logic       bus_valid;
   logic [7:0] leds;
   logic       conflict;

   typedef struct {
      logic [7:0] bo;
      logic       bv;
      logic [7:0] ld;
      logic       cf;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   fails  = 0;

   // Strobe vector bit order: {ROMO, RAMO, RAMW, SWBEN, LEDLTCH}
   localparam logic [4:0] S_NONE = 5'b00000;
   localparam logic [4:0] S_ROMO = 5'b10000;
   localparam logic [4:0] S_RAMO = 5'b01000;
   localparam logic [4:0] S_RAMW = 5'b00100;
   localparam logic [4:0] S_SWB  = 5'b00010;
   localparam logic [4:0] S_LED  = 5'b00001;

   playbus_responder #(.DATA_W(8), .ADDR_W(4), .ROM_BASE(8'h10), .ROM_STEP(3)) dut (
      .clk(clk), .reset(reset), .addr(addr), .bus_in(bus_in),
      .ROMO(ROMO), .RAMO(RAMO), .RAMW(RAMW), .SWBEN(SWBEN), .LEDLTCH(LEDLTCH),
      .switches(switches), .bus_out(bus_out), .bus_valid(bus_valid),
      .leds(leds), .conflict(conflict)
   );

   always #5 clk = ~clk;

   task automatic step(input logic rst, input logic [4:0] s, input logic [3:0] a,
                       input logic [7:0] d, input bit chk, input logic [7:0] ebo,
                       input logic ebv, input logic [7:0] eld, input logic ecf,
                       input string nm);
      exp_t e;
      @(negedge clk);
      reset = rst;
      {ROMO, RAMO, RAMW, SWBEN, LEDLTCH} = s;
      addr = a;
      bus_in = d;
      if (chk) begin
         e.bo = ebo; e.bv = ebv; e.ld = eld; e.cf = ecf; e.name = nm;
         exp_q.push_back(e);
      end
   endtask

   // Monitor: one expectation is due one edge after it was pushed.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus_out !== e.bo || bus_valid !== e.bv || leds !== e.ld || conflict !== e.cf) begin
               fails++;
               $display("FAIL %s: got bus_out=%h bus_valid=%b leds=%h conflict=%b, want bus_out=%h bus_valid=%b leds=%h conflict=%b",
                        e.name, bus_out, bus_valid, leds, conflict, e.bo, e.bv, e.ld, e.cf);
            end
         end
      end
   end

   initial begin
      reset = 1'b1; addr = '0; bus_in = '0; switches = '0;
      {ROMO, RAMO, RAMW, SWBEN, LEDLTCH} = S_NONE;

      // 1. reset
      step(1, S_NONE, 4'd0, 8'h00, 1, 8'h00, 0, 8'h00, 0, "reset_c1");
      step(1, S_NONE, 4'd0, 8'h00, 1, 8'h00, 0, 8'h00, 0, "reset_c2");
      step(0, S_NONE, 4'd0, 8'h00, 1, 8'h00, 0, 8'h00, 0, "idle");

      // 2. ROM reads
      step(0, S_ROMO, 4'd0,  8'h00, 1, 8'h10, 1, 8'h00, 0, "rom0");
      step(0, S_ROMO, 4'd5,  8'h00, 1, 8'h1F, 1, 8'h00, 0, "rom5");
      step(0, S_ROMO, 4'd15, 8'h00, 1, 8'h3D, 1, 8'h00, 0, "rom15");
      step(0, S_NONE, 4'd0,  8'h00, 1, 8'h00, 0, 8'h00, 0, "rom_idle");

      // 3. RAM write/read and read-before-write
      step(0, S_RAMW,          4'd3,  8'hA5, 1, 8'h00, 0, 8'h00, 0, "ram_wr3");
      step(0, S_RAMO,          4'd3,  8'h00, 1, 8'hA5, 1, 8'h00, 0, "ram_rd3");
      step(0, S_RAMW | S_RAMO, 4'd3,  8'h5A, 1, 8'hA5, 1, 8'h00, 0, "ram_rbw_old");
      step(0, S_RAMO,          4'd3,  8'h00, 1, 8'h5A, 1, 8'h00, 0, "ram_rbw_new");
      step(0, S_RAMW,          4'd15, 8'hE7, 1, 8'h00, 0, 8'h00, 0, "ram_wr15");
      step(0, S_RAMO,          4'd15, 8'h00, 1, 8'hE7, 1, 8'h00, 0, "ram_rd15");
      step(0, S_RAMO,          4'd3,  8'h00, 1, 8'h5A, 1, 8'h00, 0, "ram_rd3_kept");

      // 4. switch synchroniser: change lands on bus_out at the third edge
      step(0, S_SWB, 4'd0, 8'h00, 1, 8'h00, 1, 8'h00, 0, "sw_zero");
      step(0, S_SWB, 4'd0, 8'h00, 0, 8'h00, 0, 8'h00, 0, "");
      switches = 8'hC3;
      exp_q.push_back('{8'h00, 1'b1, 8'h00, 1'b0, "sw_edge1"});
      step(0, S_SWB, 4'd0, 8'h00, 1, 8'h00, 1, 8'h00, 0, "sw_edge2");
      step(0, S_SWB, 4'd0, 8'h00, 1, 8'hC3, 1, 8'h00, 0, "sw_edge3");
      step(0, S_SWB, 4'd0, 8'h00, 1, 8'hC3, 1, 8'h00, 0, "sw_hold");

      // 5. LED latch, combined with RAM write, reset discards writes
      step(0, S_LED,          4'd0, 8'h81, 1, 8'h00, 0, 8'h81, 0, "led_latch");
      step(0, S_NONE,         4'd0, 8'hFF, 1, 8'h00, 0, 8'h81, 0, "led_hold1");
      step(0, S_NONE,         4'd0, 8'h00, 1, 8'h00, 0, 8'h81, 0, "led_hold2");
      step(0, S_LED | S_RAMW, 4'd7, 8'h3C, 1, 8'h00, 0, 8'h3C, 0, "led_ramw");
      step(0, S_RAMO,         4'd7, 8'h00, 1, 8'h3C, 1, 8'h3C, 0, "ram_rd7");
      step(1, S_RAMW | S_LED, 4'd7, 8'hFF, 1, 8'h00, 0, 8'h00, 0, "led_reset");
      step(0, S_RAMO,         4'd7, 8'h00, 1, 8'h3C, 1, 8'h00, 0, "ram_kept_reset");

      // 6. conflict: sticky, does not block writes, cleared by reset
      step(0, S_ROMO | S_RAMO | S_RAMW, 4'd9, 8'h77, 1, 8'h00, 0, 8'h00, 1, "conflict_set");
      step(0, S_ROMO,          4'd5, 8'h00, 1, 8'h1F, 1, 8'h00, 1, "conflict_sticky_rom");
      step(0, S_RAMO,          4'd9, 8'h00, 1, 8'h77, 1, 8'h00, 1, "conflict_write_ok");
      step(0, S_ROMO | S_RAMO | S_SWB, 4'd0, 8'h00, 1, 8'h00, 0, 8'h00, 1, "conflict_three");
      step(0, S_RAMO | S_SWB,  4'd0, 8'h00, 1, 8'h00, 0, 8'h00, 1, "conflict_ram_sw");
      step(1, S_NONE,          4'd0, 8'h00, 1, 8'h00, 0, 8'h00, 0, "conflict_reset");
      step(0, S_ROMO,          4'd1, 8'h00, 1, 8'h13, 1, 8'h00, 0, "rom1_after_reset");
      step(0, S_NONE,          4'd0, 8'h00, 1, 8'h00, 0, 8'h00, 0, "final_idle");

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
